// File: rtl/ahb_sram_responder.sv
// AHB-Lite SRAM responder.
//
// A single-port word-organised SRAM exposed as an AHB-Lite slave occupying the
// naturally aligned region [BASE_ADDR, BASE_ADDR + 4*2^MEM_AW).
//   - Writes complete with zero wait states; the RAM is written at the end of
//     the data phase using byte enables derived from the registered size/offset.
//   - Reads take exactly one wait state: the RAM is read in the wait cycle and
//     the registered word is presented in the following cycle.
//   - Out-of-region, oversize or misaligned transfers get the standard two-cycle
//     ERROR response and never touch the RAM.
//
// Ports:
//   clk        single clock for all logic
//   rst        synchronous active-high reset (RAM contents are preserved)
//   hsel       slave select
//   htrans     transfer type (IDLE/BUSY/NONSEQ/SEQ)
//   hwrite     1 = write
//   hsize      transfer size (0 = byte, 1 = half, 2 = word)
//   haddr      byte address
//   hwdata     write data, valid in the data phase
//   hready_in  bus HREADY
//   hreadyout  slave ready
//   hrdata     read data (zero outside the read data cycle)
//   hresp      0 = OKAY, 1 = ERROR

module ahb_sram_responder #(
    parameter int unsigned MEM_AW    = 10,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        hsel,
    input  logic [1:0]  htrans,
    input  logic        hwrite,
    input  logic [2:0]  hsize,
    input  logic [31:0] haddr,
    input  logic [31:0] hwdata,
    input  logic        hready_in,
    output logic        hreadyout,
    output logic [31:0] hrdata,
    output logic        hresp
);

    localparam int unsigned Words = 2 ** MEM_AW;

    // Bits above the region size select the region; the base is region-aligned.
    localparam logic [31:0] RegionMask = ~((32'd1 << (MEM_AW + 2)) - 32'd1);

    typedef enum logic [2:0] {
        StIdle,
        StWrData,
        StRdWait,
        StRdData,
        StErr1,
        StErr2
    } state_e;

    state_e state_q, state_d;

    // Registered address phase.
    logic [MEM_AW-1:0] word_q;
    logic [1:0]        off_q;
    logic [2:0]        size_q;
    logic              write_q;

    logic        accept;
    logic        in_region;
    logic        addr_err;
    logic [3:0]  be;
    logic        mem_we;
    logic        mem_re;
    logic [31:0] rdata_q;
    logic [31:0] mem [Words];

    // SEQ and NONSEQ are handled identically, so htrans[0] carries no information.
    logic unused_htrans0;
    assign unused_htrans0 = htrans[0];

    // ------------------------------------------------------------------------
    // Address phase decode
    // ------------------------------------------------------------------------

    // hreadyout doubles as "able to accept": while stalling (RD_WAIT, ERR1) the
    // bus inputs are ignored even if hready_in is (wrongly) high.
    assign accept = hsel & htrans[1] & hready_in & hreadyout;

    assign in_region = (haddr & RegionMask) == (BASE_ADDR & RegionMask);

    always_comb begin
        addr_err = 1'b0;
        if (!in_region) begin
            addr_err = 1'b1;
        end else if (hsize > 3'd2) begin
            addr_err = 1'b1;
        end else if ((hsize == 3'd1) && haddr[0]) begin
            addr_err = 1'b1;
        end else if ((hsize == 3'd2) && (haddr[1:0] != 2'b00)) begin
            addr_err = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            word_q  <= '0;
            off_q   <= '0;
            size_q  <= '0;
            write_q <= 1'b0;
        end else if (accept) begin
            word_q  <= haddr[MEM_AW+1:2];
            off_q   <= haddr[1:0];
            size_q  <= hsize;
            write_q <= hwrite;
        end
    end

    // ------------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------------

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StRdWait: state_d = StRdData;
            StErr1:   state_d = StErr2;
            // IDLE, WR_DATA, RD_DATA and ERR2 all end a transfer and may start
            // the next one in the same cycle.
            default: begin
                if (!accept) begin
                    state_d = StIdle;
                end else if (addr_err) begin
                    state_d = StErr1;
                end else if (hwrite) begin
                    state_d = StWrData;
                end else begin
                    state_d = StRdWait;
                end
            end
        endcase
    end

    // Outputs are forced to their idle values while rst is high so a reset in
    // the middle of a stall releases the bus immediately.
    always_comb begin
        hreadyout = 1'b1;
        hresp     = 1'b0;
        hrdata    = '0;
        if (!rst) begin
            case (state_q)
                StRdWait: hreadyout = 1'b0;
                StRdData: hrdata = rdata_q;
                StErr1: begin
                    hreadyout = 1'b0;
                    hresp     = 1'b1;
                end
                StErr2:   hresp = 1'b1;
                default:  ;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // RAM
    // ------------------------------------------------------------------------

    always_comb begin
        be = 4'b0000;
        case (size_q)
            3'd0:    be = 4'b0001 << off_q;
            3'd1:    be = off_q[1] ? 4'b1100 : 4'b0011;
            3'd2:    be = 4'b1111;
            default: be = 4'b0000;
        endcase
    end

    // rst suppresses a pending write data phase.
    assign mem_we = (state_q == StWrData) & write_q & ~rst;
    assign mem_re = (state_q == StRdWait) & ~write_q & ~rst;

    // No reset: contents survive rst. A read accepted in the WR_DATA cycle is
    // performed one cycle later in RD_WAIT, so it always sees the new bytes.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[word_q][8*i +: 8] <= hwdata[8*i +: 8];
                end
            end
        end
        if (mem_re) begin
            rdata_q <= mem[word_q];
        end
    end

endmodule

// File: doc/ahb_sram_responder.md
AHB_SRAM_RESPONDER -- requirements
Module: ahb_sram_responder

Interface
REQ-001 SHALL have parameter MEM_AW, default 10, meaning word-address width (capacity 4*2^MEM_AW bytes).
REQ-002 SHALL have parameter BASE_ADDR, default 32'h0000_0000, meaning the region base, aligned to the region size.
REQ-003 SHALL have port clk, input, 1, single clock for all logic.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port hsel, input, 1, slave select.
REQ-006 SHALL have port htrans, input, 2, AHB-Lite transfer type.
REQ-007 SHALL have port hwrite, input, 1, 1=write.
REQ-008 SHALL have port hsize, input, 3, transfer size.
REQ-009 SHALL have port haddr, input, 32, byte address.
REQ-010 SHALL have port hwdata, input, 32, write data, valid in the data phase.
REQ-011 SHALL have port hready_in, input, 1, bus HREADY.
REQ-012 SHALL have port hreadyout, output, 1, slave ready.
REQ-013 SHALL have port hrdata, output, 32, read data.
REQ-014 SHALL have port hresp, output, 1, 0=OKAY, 1=ERROR.

Function
REQ-015 SHALL accept an address phase only when hsel & htrans[1] & hready_in are all 1, and SHALL register haddr, hsize and hwrite on acceptance.
REQ-016 SHALL treat IDLE/BUSY transfers, or hsel=0, as no-ops: no state change, and an OKAY response with zero wait states.
REQ-017 SHALL classify an accepted transfer as an error if any of these hold: haddr is outside [BASE_ADDR, BASE_ADDR+4*2^MEM_AW); hsize>2; hsize=1 with haddr[0]=1; or hsize=2 with haddr[1:0]!=0.
REQ-018 SHALL implement FSM states IDLE, WR_DATA, RD_WAIT, RD_DATA, ERR1 and ERR2.
REQ-019 SHALL take these transitions from IDLE, WR_DATA, RD_DATA or ERR2 when a transfer is accepted: to WR_DATA for a legal write; to RD_WAIT for a legal read; to ERR1 for an error transfer. With no transfer accepted, the FSM SHALL go to IDLE.
REQ-020 SHALL hold state WR_DATA with hreadyout=1 and hresp=0 for 0 wait states, and SHALL write hwdata into RAM at the end of that cycle.
REQ-021 SHALL derive byte enables from the registered hsize and haddr[1:0]: byte gives 1 lane; half gives lanes {1:0} or {3:2}; word gives all 4 lanes.
REQ-022 SHALL drive hreadyout=0 in RD_WAIT, issue the RAM read that cycle, and transition unconditionally to RD_DATA.
REQ-023 SHALL drive hreadyout=1, hresp=0 and hrdata = the full addressed word in RD_DATA, giving a read latency of exactly 1 wait state.
REQ-024 SHALL drive hrdata=0 in every state other than RD_DATA.
REQ-025 SHALL drive hreadyout=0 and hresp=1 in ERR1, then transition to ERR2.
REQ-026 SHALL drive hreadyout=1 and hresp=1 in ERR2.
REQ-027 SHALL NOT modify RAM in ERR1 or ERR2.
REQ-028 SHALL allow a read accepted during the WR_DATA cycle to target the just-written address, and SHALL return the newly written bytes (the write commits before the RD_WAIT read).
REQ-029 SHALL ignore all bus inputs while hreadyout=0 (RD_WAIT, ERR1): no new acceptance.
REQ-030 SHALL, for an address at the region top boundary BASE_ADDR+4*2^MEM_AW-1 with a byte access, return OKAY; the same address +1 SHALL return ERROR.

Reset
REQ-031 SHALL, while rst=1, set state=IDLE, hreadyout=1, hresp=0 and hrdata=0, and discard any registered address phase, including a pending write data phase.
REQ-032 SHALL NOT clear RAM contents on reset.
REQ-033 SHALL accept a new transfer on the first cycle after rst deasserts.

Verification
REQ-034 SHALL be verified with: word write of 32'hDEADBEEF to BASE+0x10, then word read -> hreadyout low 1 cycle, then hrdata=32'hDEADBEEF with hresp=0.
REQ-035 SHALL be verified with: byte write 8'hA5 to BASE+0x13 over 0x0, then word read of 0x10 -> 32'hA5000000.
REQ-036 SHALL be verified with: back-to-back write 0x20=32'h1234_5678 followed by a read of 0x20 accepted in the WR_DATA cycle -> 32'h1234_5678 after 1 wait state.
REQ-037 SHALL be verified with: a word read at BASE+0x2, and separately an access at BASE+4*2^MEM_AW -> hreadyout=0/hresp=1, then hreadyout=1/hresp=1, with RAM unchanged.
REQ-038 SHALL be verified with: rst asserted during RD_WAIT -> next cycle hreadyout=1, hresp=0, hrdata=0, and previously written RAM data is still readable.
REQ-039 SHALL be verified with: htrans=BUSY, and htrans=NONSEQ with hsel=0, interleaved with legal traffic -> OKAY, zero wait states, and no RAM change.
